fifo_1: RTL and testbench

Synchronous single-clock FIFO buffer, 8-bit data path, 16 entries by default. Sits between a byte producer and a byte consumer in the same clock domain. Push/pop use a per-cycle increment strobe. Status is reported through full/empty flags, a write-acknowledge pulse and a read-valid pulse.

---
 rtl/fifo_1.sv | 47 ++++
 tb/tb_fifo_1.sv | 99 +++++++++
 2 files changed

// File: rtl/fifo_1.sv
// fifo_1: single-clock byte FIFO with registered flags, write-ack and read-valid pulses
module fifo_1 #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             winc,
  input  logic [DSIZE-1:0] wdata,
  input  logic             rinc,
  output logic             wfull,
  output logic             rempty,
  output logic             wr_ack,
  output logic             rd_valid,
  output logic [DSIZE-1:0] rdata
);
  logic [DSIZE-1:0] mem [1<<ASIZE];
  logic [ASIZE:0] wptr, rptr, count, count_next;
  logic we, re;
  assign we = winc & ~wfull;
  assign re = rinc & ~rempty;
  assign count_next = count + (ASIZE+1)'(we) - (ASIZE+1)'(re);
  always_ff @(posedge clk)
    if (we && !rst) mem[wptr[ASIZE-1:0]] <= wdata;
  // count never exceeds the depth, so its MSB alone means full
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      wfull <= 1'b0;
      rempty <= 1'b1;
      wr_ack <= 1'b0;
      rd_valid <= 1'b0;
      rdata <= '0;
    end else begin
      wptr <= wptr + (ASIZE+1)'(we);
      rptr <= rptr + (ASIZE+1)'(re);
      count <= count_next;
      wfull <= count_next[ASIZE];
      rempty <= count_next == '0;
      wr_ack <= we;
      rd_valid <= re;
      if (re) rdata <= mem[rptr[ASIZE-1:0]];
    end
  end
endmodule

// File: tb/tb_fifo_1.sv
// tb_fifo_1: vector table plus queue scoreboard for fifo_1
module tb_fifo_1;
  logic clk = 1'b0, rst = 1'b1, winc = 1'b0, rinc = 1'b0;
  logic [7:0] wdata = '0, rdata;
  logic wfull, rempty, wr_ack, rd_valid;
  int nvec = 0, nerr = 0, mcount = 0, nack = 0, nrv = 0, nfull = 0;
  logic [7:0] sb [$];
  logic [7:0] e_rdata = '0;
  logic e_ack = 1'b0, e_rv = 1'b0;

  typedef struct {
    logic r, w;
    logic [7:0] d;
    logic rd, full, empty, ack, rv;
    logic [7:0] q;
  } vec_t;
  vec_t tbl [$];

  fifo_1 dut (
    .clk(clk), .rst(rst), .winc(winc), .wdata(wdata), .rinc(rinc),
    .wfull(wfull), .rempty(rempty), .wr_ack(wr_ack), .rd_valid(rd_valid), .rdata(rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic w, input logic [7:0] d, input logic rd);
    logic we, re;
    rst = r; winc = w; wdata = d; rinc = rd;
    if (r) begin
      sb.delete(); mcount = 0; e_rdata = '0; e_ack = 1'b0; e_rv = 1'b0;
    end else begin
      we = w && mcount < 16;
      re = rd && mcount > 0;
      e_ack = we; e_rv = re;
      if (we) sb.push_back(d);
      mcount = mcount + int'(we) - int'(re);
    end
    @(posedge clk); #1;
    if (e_rv) e_rdata = sb.pop_front();
    if (wr_ack) nack++;
    if (rd_valid) nrv++;
    if (wfull) nfull++;
    chk("wfull", wfull, mcount == 16);
    chk("rempty", rempty, mcount == 0);
    chk("wr_ack", wr_ack, e_ack);
    chk("rd_valid", rd_valid, e_rv);
    chk("rdata", rdata, e_rdata);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) tbl.push_back('{1, 1, 8'hff, 1, 0, 1, 0, 0, 8'h00});
    for (int i = 1; i <= 16; i++) tbl.push_back('{0, 1, 8'(i), 0, i == 16, 0, 1, 0, 8'h00});
    tbl.push_back('{0, 1, 8'd17, 0, 1, 0, 0, 0, 8'h00});
    for (int i = 1; i <= 16; i++) tbl.push_back('{0, 0, 8'h00, 1, 0, i == 16, 0, 1, 8'(i)});
    tbl.push_back('{0, 0, 8'h00, 1, 0, 1, 0, 0, 8'd16});
    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].w, tbl[i].d, tbl[i].rd);
      chk("tbl_wfull", wfull, tbl[i].full);
      chk("tbl_rempty", rempty, tbl[i].empty);
      chk("tbl_wr_ack", wr_ack, tbl[i].ack);
      chk("tbl_rd_valid", rd_valid, tbl[i].rv);
      chk("tbl_rdata", rdata, tbl[i].q);
    end
    // full FIFO: simultaneous read is taken, write of 0xAA is refused
    for (int i = 0; i < 16; i++) step(0, 1, 8'(8'h30 + i), 0);
    step(0, 1, 8'hAA, 1);
    chk("simul_full_drop", wfull, 0);
    nrv = 0;
    for (int i = 0; i < 16; i++) step(0, 0, 8'h00, 1);
    chk("simul_full_left15", nrv, 15);
    // streaming wrap with rinc held throughout
    nack = 0; nrv = 0; nfull = 0;
    for (int i = 1; i <= 156; i++) step(0, 1, 8'(i), 1);
    step(0, 0, 8'h00, 1);
    chk("stream_acks", nack, 156);
    chk("stream_valids", nrv, 156);
    chk("stream_nofull", nfull, 0);
    chk("stream_last", rdata, 156);
    // mid-operation reset discards contents
    for (int i = 0; i < 5; i++) step(0, 1, 8'(8'h60 + i), 0);
    step(1, 0, 8'h00, 0);
    step(0, 0, 8'h00, 1);
    chk("rst_mid_empty", rempty, 1);
    chk("rst_mid_rv", rd_valid, 0);
    step(0, 1, 8'h5A, 0);
    step(0, 0, 8'h00, 1);
    chk("rst_mid_5a", rdata, 8'h5A);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
